aplic_axil_reg_bridge: RTL and testbench



---
 rtl/aplic_axil_reg_bridge_if.sv | 44 ++++
 rtl/aplic_axil_reg_bridge.sv | 158 +++++++++++++++
 tb/tb_aplic_axil_reg_bridge.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aplic_axil_reg_bridge_if.sv
// Bus interfaces for the APLIC config bridge: AXI4-Lite (a32/d32) and reg_intf (a32/d32).
interface axil_if;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

interface reg_intf_if;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid;
  logic [31:0] rdata;
  logic        error;
  logic        ready;

  modport master (output addr, write, wdata, wstrb, valid, input rdata, error, ready);
  modport slave  (input addr, write, wdata, wstrb, valid, output rdata, error, ready);
endinterface

// File: rtl/aplic_axil_reg_bridge.sv
// AXI4-Lite slave to reg_intf master bridge for the APLIC config port.
// One reg_intf access in flight; AW/W/AR each buffered in a one-entry holding register.
module aplic_axil_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  axil_if.slave      s_axil,
  reg_intf_if.master reg_intf
);
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP} state_e;
  typedef enum logic {GNT_WRITE, GNT_READ} gnt_e;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e      state_q, state_d;
  gnt_e        last_q;
  logic        aw_held, w_held, ar_held;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]  w_strb_q;
  req_t        req_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [CW-1:0] tmr_q;

  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig, gnt_wr, gnt_rd, req_active, req_done, req_tmo;

  assign s_axil.awready = ~aw_held & ~i_rst;
  assign s_axil.wready  = ~w_held  & ~i_rst;
  assign s_axil.arready = ~ar_held & ~i_rst;

  assign aw_hs = s_axil.awvalid & s_axil.awready;
  assign w_hs  = s_axil.wvalid  & s_axil.wready;
  assign ar_hs = s_axil.arvalid & s_axil.arready;

  assign wr_elig    = aw_held & w_held;
  assign rd_elig    = ar_held;
  assign req_active = (state_q == WR_REQ) || (state_q == RD_REQ);

  always_comb begin
    state_d  = state_q;
    gnt_wr   = 1'b0;
    gnt_rd   = 1'b0;
    req_done = 1'b0;
    req_tmo  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie, alternate away from whichever side won last
        if (wr_elig && rd_elig) begin
          if (last_q == GNT_WRITE) gnt_rd = 1'b1;
          else                     gnt_wr = 1'b1;
        end else if (wr_elig) begin
          gnt_wr = 1'b1;
        end else if (rd_elig) begin
          gnt_rd = 1'b1;
        end
        if (gnt_wr) state_d = WR_REQ;
        if (gnt_rd) state_d = RD_REQ;
      end
      WR_REQ, RD_REQ: begin
        req_done = reg_intf.ready;
        req_tmo  = ~reg_intf.ready && (tmr_q == TMO_LAST);
        if (req_done || req_tmo) state_d = (state_q == WR_REQ) ? WR_RESP : RD_RESP;
      end
      WR_RESP: if (s_axil.bready) state_d = IDLE;
      RD_RESP: if (s_axil.rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      last_q    <= GNT_WRITE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      ar_held   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
    end else begin
      state_q <= state_d;
      // Handshake and grant never coincide on one channel: grant needs held=1, which blocks ready
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axil.awaddr;
      end else if (gnt_wr) begin
        aw_held <= 1'b0;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axil.wdata;
        w_strb_q <= s_axil.wstrb;
      end else if (gnt_wr) begin
        w_held <= 1'b0;
      end
      if (ar_hs) begin
        ar_held   <= 1'b1;
        ar_addr_q <= s_axil.araddr;
      end else if (gnt_rd) begin
        ar_held <= 1'b0;
      end
      if (gnt_wr) last_q <= GNT_WRITE;
      if (gnt_rd) last_q <= GNT_READ;
    end
  end

  // Request snapshot, wait timer and response capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (gnt_wr) begin
        req_q <= '{addr: {aw_addr_q[31:2], 2'b00}, write: 1'b1, wdata: w_data_q, wstrb: w_strb_q};
        tmr_q <= '0;
      end else if (gnt_rd) begin
        req_q <= '{addr: {ar_addr_q[31:2], 2'b00}, write: 1'b0, wdata: '0, wstrb: '0};
        tmr_q <= '0;
      end else if (req_active && !reg_intf.ready) begin
        tmr_q <= tmr_q + CW'(1);
      end
      if (req_done) begin
        err_q   <= reg_intf.error;
        rdata_q <= (state_q == RD_REQ && !reg_intf.error) ? reg_intf.rdata : '0;
      end else if (req_tmo) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  assign reg_intf.valid = req_active;
  assign reg_intf.addr  = req_active ? req_q.addr  : '0;
  assign reg_intf.write = req_active & req_q.write;
  assign reg_intf.wdata = req_active ? req_q.wdata : '0;
  assign reg_intf.wstrb = req_active ? req_q.wstrb : '0;

  assign s_axil.bvalid = (state_q == WR_RESP);
  assign s_axil.bresp  = (s_axil.bvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axil.rvalid = (state_q == RD_RESP);
  assign s_axil.rresp  = (s_axil.rvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axil.rdata  = s_axil.rvalid ? rdata_q : '0;

  logic unused_bits;
  assign unused_bits = ^{aw_addr_q[1:0], ar_addr_q[1:0]};
endmodule

// File: tb/tb_aplic_axil_reg_bridge.sv
// Self-checking bench for aplic_axil_reg_bridge: target model, reg_intf/response scoreboard,
// a vector table and hand-written corner sequences.
module tb_aplic_axil_reg_bridge;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_if     axi();
  reg_intf_if rif();

  aplic_axil_reg_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .s_axil(axi), .reg_intf(rif)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Target model: ready after tgt_wait stall cycles, or never
  int          tgt_wait = 0;
  bit          tgt_never = 1'b0;
  bit          tgt_err = 1'b0;
  logic [31:0] tgt_rdata = 32'h0;
  int          wcnt;
  always @(posedge clk or posedge rst)
    if (rst) wcnt <= 0;
    else if (!rif.valid || rif.ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  assign rif.ready = rif.valid && !tgt_never && (wcnt >= tgt_wait);
  assign rif.rdata = tgt_rdata;
  assign rif.error = tgt_err;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_exp_t;
  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } rsp_exp_t;

  req_exp_t   exp_req[$];
  logic [1:0] exp_b[$];
  rsp_exp_t   exp_r[$];

  bit       in_txn = 1'b0;
  int       vcyc = 0;
  int       last_vcyc = 0;
  req_exp_t cur;

  // Scoreboard monitor: reg_intf requests in order, plus B/R handshakes
  initial forever begin
    @(negedge clk);
    if (rif.valid) begin
      req_exp_t now, e;
      now.addr = rif.addr; now.write = rif.write; now.wdata = rif.wdata; now.wstrb = rif.wstrb;
      if (!in_txn) begin
        in_txn = 1'b1;
        vcyc = 1;
        cur = now;
        if (exp_req.size() == 0) fail("unexpected_req");
        else begin
          e = exp_req.pop_front();
          chk("req_addr", now.addr, e.addr);
          chk("req_write", {31'h0, now.write}, {31'h0, e.write});
          chk("req_wdata", now.wdata, e.wdata);
          chk("req_wstrb", {28'h0, now.wstrb}, {28'h0, e.wstrb});
        end
      end else begin
        vcyc++;
        chk("req_stable", (now == cur) ? 32'd1 : 32'd0, 32'd1);
      end
      if (rif.ready) begin in_txn = 1'b0; last_vcyc = vcyc; end
    end else if (in_txn) begin
      in_txn = 1'b0;
      last_vcyc = vcyc;
    end
    if (axi.bvalid && axi.bready) begin
      if (exp_b.size() == 0) fail("unexpected_bvalid");
      else chk("bresp", {30'h0, axi.bresp}, {30'h0, exp_b.pop_front()});
    end
    if (axi.rvalid && axi.rready) begin
      if (exp_r.size() == 0) fail("unexpected_rvalid");
      else begin
        rsp_exp_t r;
        r = exp_r.pop_front();
        chk("rresp", {30'h0, axi.rresp}, {30'h0, r.resp});
        chk("rdata", axi.rdata, r.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    axi.awaddr = a; axi.awvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (axi.awready) begin hs_cyc = cyc; step(); axi.awvalid = 1'b0; return; end
    end
    fail("aw_accept_timeout");
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (axi.wready) begin hs_cyc = cyc; step(); axi.wvalid = 1'b0; return; end
    end
    fail("w_accept_timeout");
    axi.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    axi.araddr = a; axi.arvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (axi.arready) begin hs_cyc = cyc; step(); axi.arvalid = 1'b0; return; end
    end
    fail("ar_accept_timeout");
    axi.arvalid = 1'b0;
  endtask

  task automatic wait_resp(input bit wr, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr ? axi.bvalid : axi.rvalid) begin lat = cyc - hs_cyc; break; end
    end
    if (lat < 0) fail(wr ? "bvalid_timeout" : "rvalid_timeout");
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_req.size() == 0 && exp_b.size() == 0 && exp_r.size() == 0 &&
          !axi.bvalid && !axi.rvalid && !rif.valid) begin
        step();
        return;
      end
    end
    fail("idle_timeout");
    step();
  endtask

  task automatic push_req(input logic [31:0] a, input bit wr, input logic [31:0] d, input logic [3:0] s);
    req_exp_t e;
    e.addr = a; e.write = wr; e.wdata = d; e.wstrb = s;
    exp_req.push_back(e);
  endtask

  task automatic push_r(input logic [1:0] resp, input logic [31:0] d);
    rsp_exp_t r;
    r.resp = resp; r.rdata = d;
    exp_r.push_back(r);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          never;
    bit          err;
    logic [31:0] trdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_vcyc;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int lat;
    tgt_wait = v.waits; tgt_never = v.never; tgt_err = v.err; tgt_rdata = v.trdata;
    if (v.wr) begin
      push_req(v.exp_addr, 1'b1, v.wdata, v.strb);
      exp_b.push_back(v.exp_resp);
      fork
        send_aw(v.addr);
        send_w(v.wdata, v.strb);
      join
    end else begin
      push_req(v.exp_addr, 1'b0, 32'h0, 4'h0);
      push_r(v.exp_resp, v.exp_rdata);
      send_ar(v.addr);
    end
    wait_resp(v.wr, lat);
    chk("resp_latency", lat, 32'(2 + v.exp_vcyc));
    chk("valid_cycles", last_vcyc, v.exp_vcyc);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr    addr          wdata          strb  wt nv    er    trdata         exp_addr      resp   exp_rdata      vc
    vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 2'b00, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 3, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0100, 2'b00, 32'h1234_5678, 4};
    vecs[2] = '{1'b1, 32'h0000_0A0B, 32'h0BAD_F00D, 4'h5, 1, 1'b0, 1'b0, 32'h0,         32'h0000_0A08, 2'b00, 32'h0,         2};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'h0000_0001, 4'h3, 0, 1'b0, 1'b1, 32'h0,         32'h0000_0020, 2'b10, 32'h0,         1};
    vecs[4] = '{1'b0, 32'h0000_0007, 32'h0,         4'h0, 2, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0000_0004, 2'b00, 32'hCAFE_0001, 3};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0010, 2'b10, 32'h0,         1};
    vecs[6] = '{1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hC, 0, 1'b1, 1'b0, 32'h0,         32'h0000_0030, 2'b10, 32'h0,         16};
    vecs[7] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 0, 1'b0, 1'b0, 32'h55AA_55AA, 32'h0000_0030, 2'b00, 32'h55AA_55AA, 1};
    vecs[8] = '{1'b0, 32'h0000_0034, 32'h0,         4'h0, 0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0034, 2'b10, 32'h0,         16};
    vecs[9] = '{1'b1, 32'h8000_0038, 32'h600D_CAFE, 4'hF, 0, 1'b0, 1'b0, 32'h0,         32'h8000_0038, 2'b00, 32'h0,         1};

    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.araddr = '0; axi.arvalid = 1'b0; axi.bready = 1'b1; axi.rready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {31'h0, axi.awready}, 32'h0);
    chk("rst_valid", {31'h0, rif.valid}, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_awready_rel", {31'h0, axi.awready}, 32'h1);
    chk("rst_wready_rel", {31'h0, axi.wready}, 32'h1);
    chk("rst_arready_rel", {31'h0, axi.arready}, 32'h1);
    chk("rst_bvalid", {31'h0, axi.bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, axi.rvalid}, 32'h0);
    chk("rst_bresp_rresp", {28'h0, axi.bresp, axi.rresp}, 32'h0);
    chk("rst_rdata", axi.rdata, 32'h0);
    chk("rst_req_addr", rif.addr, 32'h0);
    chk("rst_req_wdata", rif.wdata, 32'h0);
    chk("rst_req_write_strb", {27'h0, rif.write, rif.wstrb}, 32'h0);
    step();

    // Ties after reset: read first, then write; the next tie grants the read again
    for (int t = 0; t < 2; t++) begin
      logic [31:0] base;
      base = 32'h40 + 32'(t * 8);
      tgt_wait = 0; tgt_never = 1'b0; tgt_err = 1'b0; tgt_rdata = 32'hA5A5_0001 + 32'(t);
      push_req(base, 1'b0, 32'h0, 4'h0);
      push_req(base + 32'h4, 1'b1, 32'h1111_2222 + 32'(t), 4'hF);
      push_r(2'b00, 32'hA5A5_0001 + 32'(t));
      exp_b.push_back(2'b00);
      fork
        send_aw(base + 32'h4);
        send_w(32'h1111_2222 + 32'(t), 4'hF);
        send_ar(base);
      join
      wait_idle();
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Error read held under backpressure while a lone AW sits in its holding register
    tgt_wait = 0; tgt_never = 1'b0; tgt_err = 1'b1; tgt_rdata = 32'hBEEF_BEEF;
    axi.rready = 1'b0;
    push_req(32'h80, 1'b0, 32'h0, 4'h0);
    push_r(2'b10, 32'h0);
    send_ar(32'h80);
    begin
      int w;
      w = 0;
      while (!axi.rvalid && w < 50) begin @(negedge clk); w++; end
      if (!axi.rvalid) fail("bp_rvalid_timeout");
    end
    step();
    send_aw(32'h90);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid", {31'h0, axi.rvalid}, 32'h1);
      chk("bp_rresp", {30'h0, axi.rresp}, 32'h2);
      chk("bp_rdata", axi.rdata, 32'h0);
      chk("bp_awready", {31'h0, axi.awready}, 32'h0);
    end
    step();
    tgt_err = 1'b0;
    push_req(32'h90, 1'b1, 32'h0000_0077, 4'hF);
    exp_b.push_back(2'b00);
    axi.rready = 1'b1;
    send_w(32'h0000_0077, 4'hF);
    wait_idle();

    // Reset asserted mid-request: valid drops at once, no response afterwards
    tgt_never = 1'b1;
    push_req(32'hC0, 1'b1, 32'h0000_ABCD, 4'hF);
    fork
      send_aw(32'hC0);
      send_w(32'h0000_ABCD, 4'hF);
    join
    begin
      int w;
      w = 0;
      while (!rif.valid && w < 20) begin @(negedge clk); w++; end
      if (!rif.valid) fail("rstreq_valid_timeout");
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rstreq_valid", {31'h0, rif.valid}, 32'h0);
    chk("rstreq_addr", rif.addr, 32'h0);
    step();
    rst = 1'b0;
    tgt_never = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rstreq_no_bvalid", {31'h0, axi.bvalid}, 32'h0);
    end
    chk("rstreq_awready", {31'h0, axi.awready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
